// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit path: frame packing, fill policy and
// playback-buffer state encodings.
package i2s_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } tx_state_t;

  localparam int UNDERRUN_ZERO   = 0;
  localparam int UNDERRUN_REPEAT = 1;

  // A stereo frame is packed {left, right}.
  function automatic int frame_width(input int sample_bits);
    return 2 * sample_bits;
  endfunction

endpackage

// File: rtl/stereo_frame_fifo.sv
// Plain synchronous FIFO for packed stereo frames; head is read combinationally.
module stereo_frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear;

  // The extra wrap bit distinguishes full from empty when the indices match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/i2s_tx_frame_buffer.sv
// Elastic stereo playback buffer feeding the I2S transmitter: primes before
// starting, presents L for the next frame and R for the frame in flight.
module i2s_tx_frame_buffer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_BITS   = 16,
  parameter int DEPTH         = 16,
  parameter int PRIME_LEVEL   = 4,
  parameter int UNDERRUN_HOLD = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [SAMPLE_BITS-1:0]   in_sample_l,
  input  logic [SAMPLE_BITS-1:0]   in_sample_r,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [SAMPLE_BITS-1:0]   out_sample_l,
  output logic [SAMPLE_BITS-1:0]   out_sample_r,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH)+1:0] level,
  output logic                     underrun,
  output logic [15:0]              underrun_count
);

  localparam int FW = frame_width(SAMPLE_BITS);
  localparam int LW = $clog2(DEPTH) + 2;
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [FW-1:0]              head;
  logic [$clog2(DEPTH):0]     mem_count;
  logic                       mem_full;
  logic                       mem_empty;
  logic                       push;
  logic                       load;
  logic                       handshake;
  logic                       nxt_vld;
  logic signed [SAMPLE_BITS-1:0] nxt_l, nxt_r;
  logic signed [SAMPLE_BITS-1:0] cur_r;
  logic signed [SAMPLE_BITS-1:0] hold_l, hold_r;
  logic signed [SAMPLE_BITS-1:0] fill_l, fill_r;
  tx_state_t                  state, state_nxt;

  assign in_ready  = !mem_full;
  assign push      = in_valid && in_ready && !flush;
  assign handshake = out_valid && out_ready;
  // The slot refills from the memory head whenever it is empty or being consumed.
  assign load      = !mem_empty && (!nxt_vld || handshake);

  stereo_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (push),
    .push_data ({in_sample_l, in_sample_r}),
    .pop       (load && !flush),
    .head      (head),
    .count     (mem_count),
    .full      (mem_full),
    .empty     (mem_empty)
  );

  assign fill_l = (UNDERRUN_HOLD == UNDERRUN_REPEAT) ? hold_l : '0;
  assign fill_r = (UNDERRUN_HOLD == UNDERRUN_REPEAT) ? hold_r : '0;

  assign out_sample_l = nxt_vld ? nxt_l : fill_l;
  assign out_sample_r = cur_r;
  assign level        = LW'(mem_count) + LW'(nxt_vld);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PRIME;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    case (state)
      PRIME: if (level >= PRIME_LVL) state_nxt = RUN;
      RUN:   out_valid = 1'b1;
      default: state_nxt = PRIME;
    endcase
    if (flush) state_nxt = PRIME;
  end

  // Prefetch slot data: no reset needed, it is only observed while nxt_vld is set.
  always_ff @(posedge clk) begin
    if (load) {nxt_l, nxt_r} <= head;
  end

  // R of the frame in flight only moves on a handshake, so it stays stable
  // while the transmitter shifts out the left word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nxt_vld        <= 1'b0;
      cur_r          <= '0;
      hold_l         <= '0;
      hold_r         <= '0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else if (flush) begin
      nxt_vld        <= 1'b0;
      cur_r          <= '0;
      hold_l         <= '0;
      hold_r         <= '0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      if (load)           nxt_vld <= 1'b1;
      else if (handshake) nxt_vld <= 1'b0;
      if (handshake) begin
        cur_r <= nxt_vld ? nxt_r : fill_r;
        if (nxt_vld) begin
          hold_l <= nxt_l;
          hold_r <= nxt_r;
        end
      end
      underrun <= handshake && !nxt_vld;
      if (handshake && !nxt_vld) underrun_count <= sat_inc16(underrun_count);
    end
  end

endmodule

// File: tb/tb_i2s_tx_frame_buffer.sv
// Bench for i2s_tx_frame_buffer: zero-fill and hold-fill instances share stimulus
// and are compared to a queue-based playback model plus directed vectors.
module tb_i2s_tx_frame_buffer;

  localparam int SB    = 16;
  localparam int DEPTH = 16;
  localparam int PL    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_l = '0;
  logic [15:0] in_r = '0;

  logic        ir  [2];
  logic        ov  [2];
  logic [15:0] ol  [2];
  logic [15:0] orr [2];
  logic [5:0]  lvl [2];
  logic        und [2];
  logic [15:0] ucnt[2];

  int n_pass = 0;
  int n_total = 0;
  string nm[2] = '{"zero", "hold"};

  always #5 clk = ~clk;

  i2s_tx_frame_buffer #(.SAMPLE_BITS(SB), .DEPTH(DEPTH), .PRIME_LEVEL(PL), .UNDERRUN_HOLD(0)) u_zero (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_sample_l(in_l), .in_sample_r(in_r), .in_valid(in_valid), .in_ready(ir[0]),
    .out_sample_l(ol[0]), .out_sample_r(orr[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .level(lvl[0]), .underrun(und[0]), .underrun_count(ucnt[0]));

  i2s_tx_frame_buffer #(.SAMPLE_BITS(SB), .DEPTH(DEPTH), .PRIME_LEVEL(PL), .UNDERRUN_HOLD(1)) u_hold (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_sample_l(in_l), .in_sample_r(in_r), .in_valid(in_valid), .in_ready(ir[1]),
    .out_sample_l(ol[1]), .out_sample_r(orr[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .level(lvl[1]), .underrun(und[1]), .underrun_count(ucnt[1]));

  // Reference model: queue of frames, one prefetched frame, run flag, R in flight.
  logic [31:0] mq[$];
  bit          slot_v;
  logic [15:0] slot_l, slot_r;
  bit          run;
  logic [15:0] cur_r [2];
  logic [15:0] hold_l[2];
  logic [15:0] hold_r[2];
  bit          m_und;
  logic [15:0] m_ucnt;

  task automatic model_reset();
    mq.delete();
    slot_v = 0; slot_l = '0; slot_r = '0; run = 0; m_und = 0; m_ucnt = '0;
    for (int v = 0; v < 2; v++) begin
      cur_r[v] = '0; hold_l[v] = '0; hold_r[v] = '0;
    end
  endtask

  task automatic model_step(input bit f, input bit vin, input logic [15:0] l,
                            input logic [15:0] r, input bit ordy);
    int pre_size;
    int level_pre;
    bit pre_slot;
    bit hs;
    logic [31:0] fr;
    pre_size  = mq.size();
    pre_slot  = slot_v;
    level_pre = pre_size + (slot_v ? 1 : 0);
    if (f) begin
      model_reset();
      return;
    end
    hs    = run && ordy;
    m_und = hs && !pre_slot;
    if (m_und && m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
    if (hs) begin
      for (int v = 0; v < 2; v++) begin
        if (pre_slot) begin
          cur_r[v] = slot_r; hold_l[v] = slot_l; hold_r[v] = slot_r;
        end else begin
          cur_r[v] = (v == 1) ? hold_r[1] : 16'h0000;
        end
      end
    end
    if (pre_size > 0 && (!pre_slot || hs)) begin
      fr = mq.pop_front();
      slot_l = fr[31:16]; slot_r = fr[15:0]; slot_v = 1;
    end else if (hs) begin
      slot_v = 0;
    end
    if (vin && pre_size != DEPTH) mq.push_back({l, r});
    if (!run && level_pre >= PL) run = 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_all();
    logic [15:0] exp_l;
    for (int v = 0; v < 2; v++) begin
      exp_l = slot_v ? slot_l : ((v == 1) ? hold_l[1] : 16'h0000);
      chk($sformatf("%s.in_ready", nm[v]), 32'(ir[v]), 32'(mq.size() != DEPTH));
      chk($sformatf("%s.out_valid", nm[v]), 32'(ov[v]), 32'(run));
      chk($sformatf("%s.out_l", nm[v]), 32'(ol[v]), 32'(exp_l));
      chk($sformatf("%s.out_r", nm[v]), 32'(orr[v]), 32'(cur_r[v]));
      chk($sformatf("%s.level", nm[v]), 32'(lvl[v]), 32'(mq.size() + (slot_v ? 1 : 0)));
      chk($sformatf("%s.underrun", nm[v]), 32'(und[v]), 32'(m_und));
      chk($sformatf("%s.underrun_count", nm[v]), 32'(ucnt[v]), 32'(m_ucnt));
    end
  endtask

  // Starts and ends at a falling edge; outputs are checked half a cycle after the rising edge.
  task automatic tick(input bit f, input bit vin, input logic [15:0] l,
                      input logic [15:0] r, input bit ordy);
    flush = f; in_valid = vin; in_l = l; in_r = r; out_ready = ordy;
    @(posedge clk);
    model_step(f, vin, l, r, ordy);
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    bit          f, vin;
    logic [15:0] l, r;
    bit          ordy;
    bit          e_ir, e_ov;
    logic [15:0] e_l0, e_r0, e_l1, e_r1;
    logic [5:0]  e_lvl;
    bit          e_und;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{0, 1, 16'h1000, 16'h2000, 1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'd1, 0, 16'd0};
    tbl[1]  = '{0, 1, 16'h1001, 16'h2001, 1, 1, 0, 16'h1000, 16'h0000, 16'h1000, 16'h0000, 6'd2, 0, 16'd0};
    tbl[2]  = '{0, 1, 16'h1002, 16'h2002, 1, 1, 0, 16'h1000, 16'h0000, 16'h1000, 16'h0000, 6'd3, 0, 16'd0};
    tbl[3]  = '{0, 1, 16'h1003, 16'h2003, 1, 1, 0, 16'h1000, 16'h0000, 16'h1000, 16'h0000, 6'd4, 0, 16'd0};
    tbl[4]  = '{0, 0, 16'h0000, 16'h0000, 1, 1, 1, 16'h1000, 16'h0000, 16'h1000, 16'h0000, 6'd4, 0, 16'd0};
    tbl[5]  = '{0, 0, 16'h0000, 16'h0000, 1, 1, 1, 16'h1001, 16'h2000, 16'h1001, 16'h2000, 6'd3, 0, 16'd0};
    tbl[6]  = '{0, 0, 16'h0000, 16'h0000, 1, 1, 1, 16'h1002, 16'h2001, 16'h1002, 16'h2001, 6'd2, 0, 16'd0};
    tbl[7]  = '{0, 0, 16'h0000, 16'h0000, 1, 1, 1, 16'h1003, 16'h2002, 16'h1003, 16'h2002, 6'd1, 0, 16'd0};
    tbl[8]  = '{0, 0, 16'h0000, 16'h0000, 1, 1, 1, 16'h0000, 16'h2003, 16'h1003, 16'h2003, 6'd0, 0, 16'd0};
    tbl[9]  = '{0, 0, 16'h0000, 16'h0000, 1, 1, 1, 16'h0000, 16'h0000, 16'h1003, 16'h2003, 6'd0, 1, 16'd1};
    tbl[10] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 1, 16'h0000, 16'h0000, 16'h1003, 16'h2003, 6'd0, 1, 16'd2};
    tbl[11] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 1, 16'h0000, 16'h0000, 16'h1003, 16'h2003, 6'd0, 1, 16'd3};
    tbl[12] = '{0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h0000, 16'h0000, 16'h1003, 16'h2003, 6'd0, 0, 16'd3};

    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // Prime, play out four frames, then run dry for three fill frames.
    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].f, tbl[i].vin, tbl[i].l, tbl[i].r, tbl[i].ordy);
      chk($sformatf("vec%0d.in_ready", i), 32'(ir[0]), 32'(tbl[i].e_ir));
      chk($sformatf("vec%0d.out_valid", i), 32'(ov[0]), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d.zero.out_l", i), 32'(ol[0]), 32'(tbl[i].e_l0));
      chk($sformatf("vec%0d.zero.out_r", i), 32'(orr[0]), 32'(tbl[i].e_r0));
      chk($sformatf("vec%0d.hold.out_l", i), 32'(ol[1]), 32'(tbl[i].e_l1));
      chk($sformatf("vec%0d.hold.out_r", i), 32'(orr[1]), 32'(tbl[i].e_r1));
      chk($sformatf("vec%0d.level", i), 32'(lvl[0]), 32'(tbl[i].e_lvl));
      chk($sformatf("vec%0d.underrun", i), 32'(und[0]), 32'(tbl[i].e_und));
      chk($sformatf("vec%0d.underrun_count", i), 32'(ucnt[0]), 32'(tbl[i].e_cnt));
    end

    // R of the frame in flight stays put through a long stall.
    tick(1, 0, 16'h0, 16'h0, 0);
    chk("flush.level", 32'(lvl[0]), 32'd0);
    chk("flush.out_valid", 32'(ov[0]), 32'd0);
    chk("flush.underrun_count", 32'(ucnt[1]), 32'd0);
    for (int n = 0; n < 4; n++) tick(0, 1, 16'h1000 + 16'(n), 16'h2000 + 16'(n), 0);
    tick(0, 0, 16'h0, 16'h0, 0);
    tick(0, 0, 16'h0, 16'h0, 1);
    chk("stall.first_r", 32'(orr[0]), 32'h2000);
    for (int c = 0; c < 40; c++) begin
      tick(0, c == 5, 16'h1004, 16'h2004, 0);
      chk($sformatf("stall.r%0d", c), 32'(orr[0]), 32'h2000);
      chk($sformatf("stall.l%0d", c), 32'(ol[0]), 32'h1001);
    end

    // Last real frame at the sample extremes, then drain past empty.
    tick(0, 1, 16'h7FFF, 16'h8000, 1);
    for (int c = 0; c < 8; c++) tick(0, 0, 16'h0, 16'h0, 1);
    chk("repeat.hold.out_l", 32'(ol[1]), 32'h7FFF);
    chk("repeat.hold.out_r", 32'(orr[1]), 32'h8000);
    chk("repeat.zero.out_l", 32'(ol[0]), 32'h0000);
    chk("repeat.zero.out_r", 32'(orr[0]), 32'h0000);
    chk("repeat.out_valid", 32'(ov[1]), 32'd1);
    chk("repeat.underrun", 32'(und[1]), 32'd1);

    // Fill to capacity with the transmitter stalled, then drain in order.
    tick(1, 0, 16'h0, 16'h0, 0);
    for (int n = 0; n < 18; n++) tick(0, 1, 16'h3000 + 16'(n), 16'h4000 + 16'(n), 0);
    chk("full.level", 32'(lvl[0]), 32'd17);
    chk("full.in_ready", 32'(ir[0]), 32'd0);
    for (int n = 0; n < 19; n++) begin
      tick(0, 0, 16'h0, 16'h0, 1);
      if (n < 17) chk($sformatf("drain.r%0d", n), 32'(orr[0]), 32'h4000 + 32'(n));
    end

    // Flush with a same-cycle push: the push is dropped.
    tick(0, 1, 16'h5000, 16'h6000, 0);
    tick(0, 1, 16'h5001, 16'h6001, 0);
    tick(1, 1, 16'h5002, 16'h6002, 1);
    chk("flushpush.level", 32'(lvl[0]), 32'd0);
    chk("flushpush.out_valid", 32'(ov[0]), 32'd0);
    chk("flushpush.out_r", 32'(orr[0]), 32'd0);
    chk("flushpush.underrun_count", 32'(ucnt[0]), 32'd0);
    tick(0, 0, 16'h0, 16'h0, 0);
    chk("flushpush.level_after", 32'(lvl[0]), 32'd0);

    // Asynchronous reset mid-frame.
    for (int n = 0; n < 5; n++) tick(0, 1, 16'h5100 + 16'(n), 16'h6100 + 16'(n), 0);
    tick(0, 0, 16'h0, 16'h0, 1);
    tick(0, 0, 16'h0, 16'h0, 1);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int v = 0; v < 2; v++) begin
      chk($sformatf("areset.%s.out_valid", nm[v]), 32'(ov[v]), 32'd0);
      chk($sformatf("areset.%s.level", nm[v]), 32'(lvl[v]), 32'd0);
      chk($sformatf("areset.%s.out_l", nm[v]), 32'(ol[v]), 32'd0);
      chk($sformatf("areset.%s.out_r", nm[v]), 32'(orr[v]), 32'd0);
      chk($sformatf("areset.%s.in_ready", nm[v]), 32'(ir[v]), 32'd1);
      chk($sformatf("areset.%s.underrun_count", nm[v]), 32'(ucnt[v]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // Randomised traffic with drifting producer/consumer rates.
    for (int i = 0; i < 3000; i++) begin
      int ib, ob;
      bit f, vin, ordy;
      ib   = 1 + (i / 300) % 3;
      ob   = 1 + ((i / 300) + 1) % 3;
      f    = ($urandom_range(0, 149) == 0);
      vin  = ($urandom_range(0, 3) < ib);
      ordy = ($urandom_range(0, 3) < ob);
      tick(f, vin, 16'($urandom), 16'($urandom), ordy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
